// File: rtl/bcd_digit_driver.sv
// bcd_digit_driver: sequential binary-to-BCD converter (shift-and-add-3, one
// bit per cycle) with a start/busy/done handshake. Drives one registered
// 4-bit code per display; 4'hF is the blank code for the downstream decoder.
module bcd_digit_driver #(
  parameter int IN_WIDTH   = 16,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [IN_WIDTH-1:0]     value,
  input  logic                    blank_lz,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [4*NUM_DIGITS-1:0] digits
);

  localparam int CW = $clog2(IN_WIDTH + 1);
  localparam int AW = 4 * NUM_DIGITS;

  // Digit 0 shows "0", every higher digit is blank.
  localparam logic [AW-1:0] RESET_DIGITS = ~(AW'(4'hF));

  typedef enum logic {
    IDLE,
    CONVERT
  } state_t;

  state_t               state, state_next;
  logic [IN_WIDTH-1:0]  shreg, shreg_next;
  logic [AW-1:0]        acc, acc_next;
  logic                 ovf, ovf_next;
  logic [CW-1:0]        cnt;
  logic                 blank_q;
  logic                 last;
  logic [AW-1:0]        adj;
  logic [AW+IN_WIDTH-1:0] shifted;
  logic [AW-1:0]        shown;
  logic                 lead;

  assign last = (cnt == CW'(1));
  assign busy = (state == CONVERT);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of block order.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: leave IDLE on start, return after the final iteration.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch forms.
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = CONVERT;
      CONVERT: if (last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One double-dabble step: add 3 to nibbles >= 5, then shift left by one.
  always_comb begin
    adj = acc;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    shifted    = {adj, shreg} << 1;
    acc_next   = shifted[AW+IN_WIDTH-1:IN_WIDTH];
    shreg_next = shifted[IN_WIDTH-1:0];
    // A 1 leaving the top nibble means the value needs more digits.
    ovf_next   = ovf | adj[AW-1];
  end

  // Display formatting of the finished result: overflow, blanking or raw.
  always_comb begin
    shown = acc_next;
    lead  = 1'b1;
    if (ovf_next) begin
      shown = '1;
    end else if (blank_q) begin
      // Walk down from the top digit; digit 0 is never blanked.
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
        if (acc_next[4*i +: 4] != 4'd0) lead = 1'b0;
        if (lead) shown[4*i +: 4] = 4'hF;
      end
    end
  end

  // Datapath and output registers: capture on start, iterate, publish.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg    <= '0;
      acc      <= '0;
      ovf      <= 1'b0;
      cnt      <= '0;
      blank_q  <= 1'b0;
      digits   <= RESET_DIGITS;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            shreg   <= value;
            acc     <= '0;
            ovf     <= 1'b0;
            cnt     <= CW'(IN_WIDTH);
            blank_q <= blank_lz;
          end
        end
        CONVERT: begin
          shreg <= shreg_next;
          acc   <= acc_next;
          ovf   <= ovf_next;
          cnt   <= cnt - CW'(1);
          if (last) begin
            digits   <= shown;
            overflow <= ovf_next;
            done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
